pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Program-counter and instruction-fetch sequencer for the unicycle processor. It holds the architectural PC and issues fetch requests to instruction memory. It presents each fetched instruction to the decode/execute path, then advances the PC. The next PC is either PC+4 or the branch target produced by the branch adder (its `Nextinst` output) when the branch is taken.

## Interface
Parameters:
- `XLEN`, 64, PC/address width.
- `RESET_PC`, 64'h0, PC value loaded on reset.
- `ILEN`, 32, instruction width.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `branchTarget`  in  XLEN  target address from the branch adder.
- `branchTaken`  in  1  take `branchTarget` as the next PC.
- `stall`  in  1  hold the current instruction; do not advance the PC.
- `haltReq`  in  1  stop fetching after the current instruction.
- `imemReq`  out  1  fetch request to instruction memory.
- `imemAddr`  out  XLEN  fetch address; always equals `PC`.
- `imemReady`  in  1  memory response valid; `imemData` is valid this cycle.
- `imemData`  in  ILEN  fetched instruction word.
- `instrValid`  out  1  `instrOut` holds a valid instruction for the current `PC`.
- `instrOut`  out  ILEN  registered instruction.
- `PC`  out  XLEN  current program counter.
- `halted`  out  1  sequencer is in HALT.
- `fault`  out  1  a misaligned branch target was rejected; sticky.

## Operation
- States: BOOT, REQ, WAIT, ISSUE, HALT, FAULT.
- BOOT: entered on reset. All outputs are inactive. Goes to REQ on the first clock edge after `reset` deasserts.
- REQ: `imemReq`=1.
  - `imemReady`=1 in the same cycle: capture `imemData` into `instrOut` and go to ISSUE.
  - Otherwise go to WAIT.
- WAIT: `imemReq`=1 and `imemAddr` are held stable. On `imemReady`=1, capture `imemData` and go to ISSUE.
- ISSUE: `instrValid`=1 and `imemReq`=0. Input priority, evaluated per cycle:
  1. `stall`=1: hold everything and stay in ISSUE.
  2. `haltReq`=1: go to HALT. `PC` is not updated.
  3. `branchTaken`=1 with `branchTarget[1:0]`≠0: go to FAULT. `PC` is not updated.
  4. `branchTaken`=1: `PC` ← `branchTarget`, go to REQ.
  5. Otherwise: `PC` ← `PC`+4, go to REQ.
- HALT: terminal until reset. `halted`=1, `instrValid`=0, `imemReq`=0.
- FAULT: terminal until reset. `fault`=1, `instrValid`=0, `imemReq`=0.
- `branchTaken` and `branchTarget` are sampled only in ISSUE with `stall`=0. They are ignored in every other state.
- `imemReady` is ignored outside REQ/WAIT. `instrOut` keeps its last value until the next capture.
- Arithmetic: `PC`+4 is unsigned modulo 2^XLEN, so `PC`=2^XLEN−4 wraps to 0. `branchTarget` is used as-is; no sign extension is done here.

## Timing
- Reset values: `PC`=RESET_PC, `imemAddr`=RESET_PC, `imemReq`=0, `instrValid`=0, `instrOut`=0, `halted`=0, `fault`=0, state=BOOT.
- Reset is asynchronous. Asserting `reset` in any state, including WAIT with a request outstanding, forces the reset values immediately, without waiting for a clock edge. A memory response arriving during or after reset is discarded.
- `imemReq`, `instrValid`, `halted` and `fault` decode from registered state only. None of them is combinational from any input.
- Latency from reset release:
  - Edge 1: BOOT→REQ; `imemReq` rises.
  - With zero-wait memory, `instrValid` rises after edge 2.
- Throughput: 2 cycles per instruction with zero-wait memory and no stall. Each memory wait cycle adds 1 cycle; each stalled cycle adds 1 cycle.
- `PC` changes only on the ISSUE→REQ edge. `imemAddr` follows in the same cycle.

## Test plan
- Sequential fetch: RESET_PC=0, `imemReady` always 1, memory returns 32'h11110000+addr. Required:
  - `PC` runs 0, 4, 8, 12.
  - `instrValid` is high every second cycle.
  - `instrOut` matches the address.
- Taken branch: at `PC`=8 assert `branchTaken`=1 with `branchTarget`=64'h40. Required: the next `imemAddr` is 64'h40, followed by 64'h44.
- Wait states and stall: hold `imemReady` low for 3 cycles at `PC`=4, then assert `stall` for 2 cycles in ISSUE. Required:
  - `imemReq` and `imemAddr`=4 stay stable through WAIT.
  - `instrValid` is held during the stall.
  - `PC` advances to 8 only after `stall` drops.
- Misaligned target and halt:
  - `branchTarget`=64'h42 with `branchTaken`=1 at `PC`=4. Required: `fault`=1, `PC` stays 4, `imemReq` stays 0.
  - Separate run: `haltReq`=1 at `PC`=12. Required: `halted`=1, `PC`=12.
- Wrap-around: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC. Required: the second fetch address is 64'h0.
- Reset mid-WAIT: assert `reset` between clock edges while in WAIT at `PC`=8. Required:
  - `imemReq`=0 and `PC`=RESET_PC before the next clock edge.
  - After release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Program-counter and instruction-fetch sequencer: owns the architectural PC,
// issues fetches to instruction memory and presents one instruction at a time.
module pc_fetch_sequencer #(
   parameter int unsigned     XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = 64'h0,
   parameter int unsigned     ILEN     = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] branchTarget,
   input  logic            branchTaken,
   input  logic            stall,
   input  logic            haltReq,
   output logic            imemReq,
   output logic [XLEN-1:0] imemAddr,
   input  logic            imemReady,
   input  logic [ILEN-1:0] imemData,
   output logic            instrValid,
   output logic [ILEN-1:0] instrOut,
   output logic [XLEN-1:0] PC,
   output logic            halted,
   output logic            fault
);

   typedef enum logic [2:0] {
      BOOT  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      ISSUE = 3'd3,
      HALT  = 3'd4,
      FAULT = 3'd5
   } state_t;

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(64'd4);

   state_t          state_r;
   logic [XLEN-1:0] pc_r;
   logic [ILEN-1:0] instr_r;
   logic            req_r;
   logic            valid_r;
   logic            halted_r;
   logic            fault_r;
   logic            misaligned_s;

   assign misaligned_s = (branchTarget[1:0] != 2'b00);

   // Fetch FSM; every status output is a register updated with the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= BOOT;
         pc_r     <= RESET_PC;
         instr_r  <= '0;
         req_r    <= 1'b0;
         valid_r  <= 1'b0;
         halted_r <= 1'b0;
         fault_r  <= 1'b0;
      end else begin
         case (state_r)
            BOOT: begin
               state_r <= REQ;
               req_r   <= 1'b1;
            end
            REQ, WAIT: begin
               if (imemReady) begin
                  instr_r <= imemData;
                  req_r   <= 1'b0;
                  valid_r <= 1'b1;
                  state_r <= ISSUE;
               end else begin
                  state_r <= WAIT;
               end
            end
            ISSUE: begin
               if (stall) begin
                  state_r <= ISSUE;
               end else if (haltReq) begin
                  valid_r  <= 1'b0;
                  halted_r <= 1'b1;
                  state_r  <= HALT;
               end else if (branchTaken && misaligned_s) begin
                  valid_r <= 1'b0;
                  fault_r <= 1'b1;
                  state_r <= FAULT;
               end else if (branchTaken) begin
                  pc_r    <= branchTarget;
                  valid_r <= 1'b0;
                  req_r   <= 1'b1;
                  state_r <= REQ;
               end else begin
                  // Unsigned add wraps naturally at 2^XLEN.
                  pc_r    <= pc_r + PC_STEP;
                  valid_r <= 1'b0;
                  req_r   <= 1'b1;
                  state_r <= REQ;
               end
            end
            HALT: begin
               state_r <= HALT;
            end
            FAULT: begin
               state_r <= FAULT;
            end
            default: begin
               state_r  <= BOOT;
               req_r    <= 1'b0;
               valid_r  <= 1'b0;
               halted_r <= 1'b0;
               fault_r  <= 1'b0;
            end
         endcase
      end
   end

   assign PC         = pc_r;
   assign imemAddr   = pc_r;
   assign imemReq    = req_r;
   assign instrValid = valid_r;
   assign instrOut   = instr_r;
   assign halted     = halted_r;
   assign fault      = fault_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer; a second instance
// with RESET_PC near the top of the address space covers PC wrap-around.
module tb_pc_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] branch_target = 64'h0;
   logic        branch_taken = 1'b0;
   logic        stall = 1'b0;
   logic        halt_req = 1'b0;
   logic        imem_ready = 1'b0;

   logic        imem_req, instr_valid, halted, fault;
   logic [63:0] imem_addr, pc;
   logic [31:0] imem_data, instr_out;

   logic        w_imem_req, w_instr_valid, w_halted, w_fault;
   logic [63:0] w_imem_addr, w_pc;
   logic [31:0] w_imem_data, w_instr_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign imem_data   = 32'h1111_0000 + imem_addr[31:0];
   assign w_imem_data = 32'h1111_0000 + w_imem_addr[31:0];

   pc_fetch_sequencer #(.XLEN(64), .RESET_PC(64'h0), .ILEN(32)) dut (
      .clk(clk), .reset(reset), .branchTarget(branch_target), .branchTaken(branch_taken),
      .stall(stall), .haltReq(halt_req), .imemReq(imem_req), .imemAddr(imem_addr),
      .imemReady(imem_ready), .imemData(imem_data), .instrValid(instr_valid),
      .instrOut(instr_out), .PC(pc), .halted(halted), .fault(fault)
   );

   pc_fetch_sequencer #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .ILEN(32)) dut_wrap (
      .clk(clk), .reset(reset), .branchTarget(branch_target), .branchTaken(branch_taken),
      .stall(stall), .haltReq(halt_req), .imemReq(w_imem_req), .imemAddr(w_imem_addr),
      .imemReady(imem_ready), .imemData(w_imem_data), .instrValid(w_instr_valid),
      .instrOut(w_instr_out), .PC(w_pc), .halted(w_halted), .fault(w_fault)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves both instances in REQ (edge 1 after reset release).
   task automatic restart();
      branch_taken = 1'b0; stall = 1'b0; halt_req = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic run_to_issue(input logic [63:0] target);
      bit found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (instr_valid === 1'b1 && pc === target) begin
            found = 1'b1;
            break;
         end
         step();
      end
      if (found !== 1'b1) begin
         $display("FAIL run_to_issue: timeout, pc=%h wanted ISSUE at %h", pc, target);
         failures++;
      end
      checks++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      if (pc !== 64'h0) begin $display("FAIL reset_pc: got %h want 0", pc); failures++; end
      checks++;
      if (imem_addr !== 64'h0) begin $display("FAIL reset_addr: got %h want 0", imem_addr); failures++; end
      checks++;
      if ({imem_req, instr_valid, halted, fault} !== 4'b0000) begin
         $display("FAIL reset_flags: got %b want 0000", {imem_req, instr_valid, halted, fault}); failures++;
      end
      checks++;
      if (instr_out !== 32'h0) begin $display("FAIL reset_instr: got %h want 0", instr_out); failures++; end
      checks++;
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      logic [63:0] exp_pc;
      imem_ready = 1'b1;
      step();
      if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
         $display("FAIL seq_edge1: req=%b valid=%b want req=1 valid=0", imem_req, instr_valid); failures++;
      end
      checks++;
      for (int k = 0; k < 4; k++) begin
         exp_pc = 64'(4 * k);
         step();
         if (instr_valid !== 1'b1 || pc !== exp_pc || instr_out !== 32'h1111_0000 + exp_pc[31:0]) begin
            $display("FAIL seq_issue%0d: valid=%b pc=%h instr=%h want 1 %h %h", k, instr_valid, pc,
                     instr_out, exp_pc, 32'h1111_0000 + exp_pc[31:0]);
            failures++;
         end
         checks++;
         step();
         if (instr_valid !== 1'b0 || imem_req !== 1'b1 || pc !== exp_pc + 64'd4) begin
            $display("FAIL seq_req%0d: valid=%b req=%b pc=%h want 0 1 %h", k, instr_valid, imem_req,
                     pc, exp_pc + 64'd4);
            failures++;
         end
         checks++;
      end
   endtask

   task automatic test_branch();
      imem_ready = 1'b1;
      restart();
      run_to_issue(64'h8);
      branch_taken = 1'b1;
      branch_target = 64'h40;
      step();
      branch_taken = 1'b0;
      if (imem_addr !== 64'h40 || imem_req !== 1'b1) begin
         $display("FAIL branch_target: addr=%h req=%b want 40 1", imem_addr, imem_req); failures++;
      end
      checks++;
      step();
      if (instr_out !== 32'h1111_0040) begin $display("FAIL branch_instr: got %h want 11110040", instr_out); failures++; end
      checks++;
      step();
      if (imem_addr !== 64'h44) begin $display("FAIL branch_next: got %h want 44", imem_addr); failures++; end
      checks++;
   endtask

   task automatic test_wait_stall();
      imem_ready = 1'b1;
      restart();
      run_to_issue(64'h0);
      imem_ready = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         if (imem_req !== 1'b1 || imem_addr !== 64'h4 || instr_valid !== 1'b0) begin
            $display("FAIL wait_hold%0d: req=%b addr=%h valid=%b want 1 4 0", i, imem_req, imem_addr, instr_valid);
            failures++;
         end
         checks++;
         step();
      end
      imem_ready = 1'b1;
      stall = 1'b1;
      step();
      if (instr_valid !== 1'b1 || instr_out !== 32'h1111_0004) begin
         $display("FAIL wait_capture: valid=%b instr=%h want 1 11110004", instr_valid, instr_out); failures++;
      end
      checks++;
      for (int i = 0; i < 2; i++) begin
         step();
         if (instr_valid !== 1'b1 || pc !== 64'h4 || imem_req !== 1'b0) begin
            $display("FAIL stall_hold%0d: valid=%b pc=%h req=%b want 1 4 0", i, instr_valid, pc, imem_req);
            failures++;
         end
         checks++;
      end
      stall = 1'b0;
      step();
      if (pc !== 64'h8 || imem_req !== 1'b1) begin
         $display("FAIL stall_release: pc=%h req=%b want 8 1", pc, imem_req); failures++;
      end
      checks++;
   endtask

   task automatic test_fault();
      imem_ready = 1'b1;
      restart();
      run_to_issue(64'h4);
      branch_taken = 1'b1;
      branch_target = 64'h42;
      step();
      branch_taken = 1'b0;
      if (fault !== 1'b1 || pc !== 64'h4 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         $display("FAIL fault_entry: fault=%b pc=%h req=%b valid=%b want 1 4 0 0", fault, pc, imem_req, instr_valid);
         failures++;
      end
      checks++;
      step();
      step();
      if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== 64'h4) begin
         $display("FAIL fault_sticky: fault=%b req=%b pc=%h want 1 0 4", fault, imem_req, pc); failures++;
      end
      checks++;
   endtask

   task automatic test_halt();
      imem_ready = 1'b1;
      restart();
      run_to_issue(64'hC);
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      if (halted !== 1'b1 || pc !== 64'hC || imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0) begin
         $display("FAIL halt_entry: halted=%b pc=%h req=%b valid=%b fault=%b want 1 c 0 0 0",
                  halted, pc, imem_req, instr_valid, fault);
         failures++;
      end
      checks++;
      step();
      if (halted !== 1'b1 || imem_req !== 1'b0) begin
         $display("FAIL halt_sticky: halted=%b req=%b want 1 0", halted, imem_req); failures++;
      end
      checks++;
   endtask

   task automatic test_wrap();
      imem_ready = 1'b1;
      restart();
      if (w_imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC || w_imem_req !== 1'b1) begin
         $display("FAIL wrap_first: addr=%h req=%b want fffffffffffffffc 1", w_imem_addr, w_imem_req); failures++;
      end
      checks++;
      step();
      if (w_instr_out !== 32'h1110_FFFC) begin $display("FAIL wrap_instr: got %h want 1110fffc", w_instr_out); failures++; end
      checks++;
      step();
      if (w_imem_addr !== 64'h0 || w_imem_req !== 1'b1) begin
         $display("FAIL wrap_second: addr=%h req=%b want 0 1", w_imem_addr, w_imem_req); failures++;
      end
      checks++;
   endtask

   task automatic test_reset_mid_wait();
      imem_ready = 1'b1;
      restart();
      run_to_issue(64'h4);
      imem_ready = 1'b0;
      step();
      step();
      if (imem_req !== 1'b1 || imem_addr !== 64'h8) begin
         $display("FAIL rstwait_pre: req=%b addr=%h want 1 8", imem_req, imem_addr); failures++;
      end
      checks++;
      #2;
      reset = 1'b1;
      #1;
      if (imem_req !== 1'b0 || pc !== 64'h0 || instr_valid !== 1'b0) begin
         $display("FAIL rstwait_async: req=%b pc=%h valid=%b want 0 0 0", imem_req, pc, instr_valid); failures++;
      end
      checks++;
      imem_ready = 1'b1;
      step();
      if (instr_out !== 32'h0 || imem_req !== 1'b0) begin
         $display("FAIL rstwait_discard: instr=%h req=%b want 0 0", instr_out, imem_req); failures++;
      end
      checks++;
      reset = 1'b0;
      step();
      if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
         $display("FAIL rstwait_restart: req=%b addr=%h want 1 0", imem_req, imem_addr); failures++;
      end
      checks++;
      step();
      if (instr_valid !== 1'b1 || instr_out !== 32'h1111_0000) begin
         $display("FAIL rstwait_first: valid=%b instr=%h want 1 11110000", instr_valid, instr_out); failures++;
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_wait_stall();
      test_fault();
      test_halt();
      test_wrap();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
